dtc_vote_collector: RTL
=======================

Name: dtc_vote_collector

Overview:
- Sequential front/back end for a combinational decision-tree classifier: 12-bit feature vector in, 3-bit class out.
- Accepts feature vectors over a valid/ready stream and drives each one into the classifier.
- Captures the returned class and counts votes per class over a window of WINDOW samples.
- At the end of each window, emits the majority class and its vote count on a valid/ready result stream.

Parameters:
WINDOW, 8, samples per vote window (1..255); CNT_W derived = clog2(WINDOW+1).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
s_valid  in  1  feature vector valid
s_ready  out  1  collector can accept a feature vector
s_feat  in  12  feature vector
dt_inp  out  12  registered feature vector to classifier input
dt_outp  in  3  classifier class output (combinational function of dt_inp)
m_valid  out  1  window result valid
m_ready  in  1  downstream accepts result
m_class  out  3  majority class
m_count  out  CNT_W  votes received by m_class

Behaviour:
- Reset: one clock (clk); asynchronous active-low reset (rst_n). On reset, clear all state immediately regardless of phase:
  - state=ACCUM, n_acc=0, all 8 vote counters=0, feat_vld_q=0
  - dt_inp=0, s_ready=1 after reset release
  - m_valid=0, m_class=0, m_count=0
- Handshake: a transfer occurs on a rising edge where valid&ready=1. s_ready=1 only when state==ACCUM and n_acc<WINDOW.
- Stage 1 (accept edge): dt_inp<=s_feat; feat_vld_q<=1; n_acc<=n_acc+1. Without an accept, feat_vld_q<=0 and dt_inp holds its value.
- Stage 2 (next edge, feat_vld_q=1): votes[dt_outp]<=votes[dt_outp]+1. Counters are CNT_W wide; they cannot overflow because the total is bounded by WINDOW.
- FSM states and transitions:
  - ACCUM: accept samples. When n_acc==WINDOW, go to SCAN on the same edge that applies the last vote.
  - SCAN: idx runs 0..7, one class per cycle. Starts with best_cnt=0, best_cls=0. Replace best when votes[idx] > best_cnt (strictly greater), so ties resolve to the lowest class index. When idx==7, go to DONE; m_class/m_count load best_cls/best_cnt, including the idx-7 comparison.
  - DONE: m_valid=1; m_class and m_count stable while m_ready=0. When m_ready=1: m_valid<=0, all votes<=0, n_acc<=0, go to ACCUM.
- Latency: if the last sample handshakes at edge t, m_valid rises after edge t+10 (1 vote edge + 8 SCAN edges + DONE load).
- s_ready is 0 from the edge after the WINDOW-th accept until ACCUM is re-entered. No samples are accepted during SCAN or DONE.
- WINDOW=1: each sample yields its own result; m_count=1.
- Reset asserted mid-SCAN or mid-DONE discards the partial result; the held m_valid drops asynchronously.
- dt_outp is sampled only when feat_vld_q=1; at other times its value is ignored.

Decomposition:
- Shared package dtc_pkg:
  - FEAT_W=12, CLASS_W=3, N_CLASS=8
  - state enum {ACCUM, SCAN, DONE}
  - helper function for CNT_W derivation
- One sub-module: dtc_vote_bank. Holds 8 counters of CNT_W bits and provides:
  - inc_en/inc_cls increment port
  - clr synchronous clear
  - rd_idx/rd_cnt read port used by SCAN
- Top level holds the FSM, n_acc, the stage-1 register, and the argmax registers.

Test Plan:
All scenarios use a bench classifier stub dt_outp = dt_inp[2:0] and WINDOW=8 unless stated.
1. Reset, then 8 samples with s_feat[2:0]=5, back-to-back, m_ready=1 -> m_valid rises 10 edges after the 8th handshake; m_class=5, m_count=8; s_ready=0 from the 9th edge.
2. Classes 3,3,6,6,6,1,3,6 -> m_class=6, m_count=4. Then classes 2,2,2,2,4,4,4,4 (tie) -> m_class=2, m_count=4.
3. Hold m_ready=0 for 20 cycles in DONE -> m_valid, m_class, m_count stable, s_ready=0. Raise m_ready -> one-cycle completion; s_ready=1 next cycle; new window counts from 0.
4. s_valid toggled randomly (50%) with classes all 7 -> result is 7/8 regardless of gaps; no sample is lost or double-counted.
5. Assert rst_n=0 mid-SCAN after 8 samples of class 4 -> outputs clear immediately. Then 8 samples of class 0 -> m_class=0, m_count=8, with no residue from the class-4 votes.
6. WINDOW=1 build: single sample of class 2 -> m_class=2, m_count=1, m_valid 10 edges after the handshake.

Source files
------------

// File: rtl/dtc_vote_collector_pkg.sv
// Shared constants, FSM state type and counter-width helper for the
// decision-tree vote collector.
package dtc_pkg;
    localparam int unsigned FEAT_W  = 12;
    localparam int unsigned CLASS_W = 3;
    localparam int unsigned N_CLASS = 8;

    typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

    // Counter wide enough to hold the value WINDOW itself.
    function automatic int unsigned cnt_w(input int unsigned window);
        return $clog2(window + 1);
    endfunction
endpackage

// File: rtl/dtc_vote_collector_if.sv
// Feature-in / result-out streams plus the classifier side-channel.
interface dtc_vote_collector_if import dtc_pkg::*; #(
    parameter int unsigned WINDOW = 8
);
    localparam int unsigned CNT_W = cnt_w(WINDOW);

    logic               s_valid;
    logic               s_ready;
    logic [FEAT_W-1:0]  s_feat;
    logic [FEAT_W-1:0]  dt_inp;
    logic [CLASS_W-1:0] dt_outp;
    logic               m_valid;
    logic               m_ready;
    logic [CLASS_W-1:0] m_class;
    logic [CNT_W-1:0]   m_count;

    modport slave (
        input  s_valid, s_feat, dt_outp, m_ready,
        output s_ready, dt_inp, m_valid, m_class, m_count
    );

    modport master (
        output s_valid, s_feat, dt_outp, m_ready,
        input  s_ready, dt_inp, m_valid, m_class, m_count
    );
endinterface

// File: rtl/dtc_vote_bank.sv
// Per-class vote counters with increment, synchronous clear and one
// combinational read port.
module dtc_vote_bank import dtc_pkg::*; #(
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_inc_en,
    input  logic [CLASS_W-1:0] i_inc_cls,
    input  logic               i_clr,
    input  logic [CLASS_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0]   o_rd_cnt
);
    logic [CNT_W-1:0] r_votes [N_CLASS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CLASS; i++) r_votes[i] <= '0;
        end else if (i_clr) begin
            for (int unsigned i = 0; i < N_CLASS; i++) r_votes[i] <= '0;
        end else if (i_inc_en) begin
            r_votes[i_inc_cls] <= r_votes[i_inc_cls] + CNT_W'(1);
        end
    end

    assign o_rd_cnt = r_votes[i_rd_idx];
endmodule

// File: rtl/dtc_vote_collector.sv
// Feeds feature vectors to an external combinational classifier, tallies the
// returned classes over WINDOW samples and reports the majority class.
module dtc_vote_collector import dtc_pkg::*; #(
    parameter int unsigned WINDOW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dtc_vote_collector_if.slave  bus
);
    localparam int unsigned      CNT_W = cnt_w(WINDOW);
    localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);
    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(N_CLASS - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_n_acc;
    logic               r_feat_vld;
    logic [FEAT_W-1:0]  r_dt_inp;
    logic [CLASS_W-1:0] r_idx, r_best_cls, r_m_class;
    logic [CNT_W-1:0]   r_best_cnt, r_m_count;
    logic               r_m_valid;
    logic [CNT_W-1:0]   w_rd_cnt;
    logic               w_s_ready, w_accept, w_better, w_clr;

    assign w_s_ready = (r_state == ACCUM) && (r_n_acc < WIN_C);
    assign w_accept  = bus.s_valid && w_s_ready;
    assign w_better  = w_rd_cnt > r_best_cnt;
    assign w_clr     = (r_state == DONE) && r_m_valid && bus.m_ready;

    dtc_vote_bank #(.CNT_W(CNT_W)) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inc_en  (r_feat_vld),
        .i_inc_cls (bus.dt_outp),
        .i_clr     (w_clr),
        .i_rd_idx  (r_idx),
        .o_rd_cnt  (w_rd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    // Leaving ACCUM coincides with the last vote landing in the bank.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (r_n_acc == WIN_C)   w_state_nxt = SCAN;
            SCAN:    if (r_idx == LAST_IDX)  w_state_nxt = DONE;
            DONE:    if (w_clr)              w_state_nxt = ACCUM;
            default:                         w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dt_inp   <= '0;
            r_feat_vld <= 1'b0;
            r_n_acc    <= '0;
        end else begin
            r_feat_vld <= w_accept;
            if (w_accept) r_dt_inp <= bus.s_feat;
            if (w_clr)         r_n_acc <= '0;
            else if (w_accept) r_n_acc <= r_n_acc + CNT_W'(1);
        end
    end

    // Strict '>' keeps the lowest class index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
        end else if (r_state == ACCUM && w_state_nxt == SCAN) begin
            r_idx      <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
        end else if (r_state == SCAN) begin
            r_idx <= r_idx + CLASS_W'(1);
            if (w_better) begin
                r_best_cls <= r_idx;
                r_best_cnt <= w_rd_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_class <= '0;
            r_m_count <= '0;
        end else if (r_state == DONE && !r_m_valid) begin
            r_m_valid <= 1'b1;
            r_m_class <= r_best_cls;
            r_m_count <= r_best_cnt;
        end else if (w_clr) begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.dt_inp  = r_dt_inp;
    assign bus.m_valid = r_m_valid;
    assign bus.m_class = r_m_class;
    assign bus.m_count = r_m_count;
endmodule
